// File: rtl/add16_mp_sequencer.sv
// rtl/add16_mp_sequencer.sv - multi-precision adder sequencing one shared 16-bit adder, LSW first

module add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
endmodule

module add16_mp_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] sum,
    output logic                cout
);
    localparam int W  = 16 * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          carry;
    logic          accept;
    logic          last_word;
    logic [15:0]   a_word;
    logic [15:0]   b_word;
    logic [15:0]   word_sum;
    logic          word_cout;

    // A start is only honoured when no operation is in flight.
    assign accept    = start && (state != RUN);
    assign last_word = (idx == IW'(WORDS - 1));

    always_comb begin
        a_word = op_a[idx*16 +: 16];
        b_word = op_b[idx*16 +: 16];
    end

    add16 u_add16 (
        .a    (a_word),
        .b    (b_word),
        .cin  (carry),
        .sum  (word_sum),
        .cout (word_cout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = accept ? RUN : IDLE;
            RUN:     state_nxt = last_word ? DONE : RUN;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // sum and cout are left untouched at accept so the last result stays readable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum[idx*16 +: 16] <= word_sum;
            carry             <= word_cout;
            idx               <= idx + 1'b1;
            if (last_word) begin
                cout <= word_cout;
            end
        end
    end
endmodule

// File: tb/tb_add16_mp_sequencer.sv
// tb/tb_add16_mp_sequencer.sv - randomized self-checking bench for add16_mp_sequencer

module tb_add16_mp_sequencer;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;
    localparam int LIMIT = 40;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int passed = 0;
    int total  = 0;

    add16_mp_sequencer #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++) begin
            case ($urandom_range(0, 3))
                0:       v[i*16 +: 16] = 16'hFFFF;
                1:       v[i*16 +: 16] = 16'h0000;
                default: v[i*16 +: 16] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    // Pulses start for one edge, then waits (bounded) for done; lat counts edges after the accept edge.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, output int lat);
        @(negedge clk);
        start = 1'b1; a = x; b = y; cin = c;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        total++;
        if ({busy, done, cout, sum} !== {3'b000, {W{1'b0}}}) begin
            $display("FAIL reset_state: busy=%b done=%b cout=%b sum=%h, required all zero", busy, done, cout, sum);
        end else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_zero_timing();
        int bad = 0;
        @(negedge clk);
        start = 1'b1; a = '0; b = '0; cin = 1'b0;
        for (int k = 0; k < WORDS; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL zero_busy_window: %0d cycles wrong, required busy=1 done=0 for %0d cycles", bad, WORDS);
        else passed++;
        @(negedge clk);
        total++;
        if ({busy, done, cout, sum} !== {3'b010, {W{1'b0}}})
            $display("FAIL zero_done: busy=%b done=%b cout=%b sum=%h, required busy=0 done=1 result 0", busy, done, cout, sum);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL zero_done_width: done=%b busy=%b, required 0 0", done, busy);
        else passed++;
    endtask

    task automatic test_directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic [W:0] req);
        int lat;
        run_op(x, y, c, lat);
        total++;
        if (lat !== WORDS) $display("FAIL %s_latency: %0d edges, required %0d", name, lat, WORDS);
        else passed++;
        total++;
        if ({cout, sum} !== req) $display("FAIL %s_result: got %b_%h, required %b_%h", name, cout, sum, req[W], req[W-1:0]);
        else passed++;
    endtask

    task automatic test_mid_run_start();
        logic [W-1:0] x = 64'h1234_5678_9ABC_DEF0;
        logic [W-1:0] y = 64'h0FED_CBA9_8765_4321;
        logic [W:0]   got = '0;
        int dones = 0;
        @(negedge clk);
        start = 1'b1; a = x; b = y; cin = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            start = (k == 1 || k == 2);
            a = rand_operand(); b = rand_operand(); cin = 1'($urandom);
            if (done) begin
                dones++;
                got = {cout, sum};
            end
        end
        start = 1'b0;
        total++;
        if (dones != 1) $display("FAIL midrun_done_count: %0d pulses, required 1", dones);
        else passed++;
        total++;
        if (got !== {1'b0, 64'h2222_2222_2222_2211})
            $display("FAIL midrun_result: got %b_%h, required 0_2222222222222211", got[W], got[W-1:0]);
        else passed++;
    endtask

    task automatic test_async_reset();
        int dones = 0;
        int lat;
        @(negedge clk);
        start = 1'b1; a = rand_operand() | 64'h1; b = rand_operand(); cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        total++;
        if ({busy, done, cout, sum} !== {3'b000, {W{1'b0}}})
            $display("FAIL async_reset: busy=%b done=%b cout=%b sum=%h, required all zero", busy, done, cout, sum);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        total++;
        if (dones != 0) $display("FAIL async_reset_quiet: %0d active cycles after reset, required 0", dones);
        else passed++;
        run_op(64'd5, 64'd5, 1'b0, lat);
        total++;
        if (lat !== WORDS || {cout, sum} !== 65'd10)
            $display("FAIL after_reset_op: lat=%0d sum=%h cout=%b, required lat=%0d sum=10 cout=0", lat, sum, cout, WORDS);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2 = 0;
        run_op(64'd10, 64'd1, 1'b0, lat1);
        total++;
        if (lat1 !== WORDS || {cout, sum} !== 65'd11)
            $display("FAIL b2b_first: lat=%0d sum=%h cout=%b, required lat=%0d sum=11", lat1, sum, cout, WORDS);
        else passed++;
        start = 1'b1; a = 64'hFFFF; b = 64'd1; cin = 1'b0;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", busy, done);
        else passed++;
        while (!done && lat2 < LIMIT) begin
            @(negedge clk);
            lat2++;
        end
        total++;
        if (lat2 !== WORDS || {cout, sum} !== 65'h1_0000)
            $display("FAIL b2b_second: lat=%0d sum=%h cout=%b, required lat=%0d sum=10000", lat2, sum, cout, WORDS);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if ({cout, sum} !== 65'h1_0000 || busy !== 1'b0)
            $display("FAIL idle_hold: sum=%h cout=%b busy=%b, required sum=10000 held", sum, cout, busy);
        else passed++;
    endtask

    task automatic test_random();
        int errs = 0;
        int lat;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic c;
        logic [W:0] req;
        for (int n = 0; n < 30; n++) begin
            x = rand_operand(); y = rand_operand(); c = 1'($urandom);
            req = model(x, y, c);
            run_op(x, y, c, lat);
            total++;
            if (lat !== WORDS || {cout, sum} !== req) begin
                errs++;
                $display("FAIL random_%0d: lat=%0d got %b_%h, required lat=%0d %b_%h", n, lat, cout, sum, WORDS, req[W], req[W-1:0]);
            end else passed++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_zero_timing();
        test_directed("carry_w0w1", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, {1'b0, 64'h0000_0000_0001_0000});
        test_directed("full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, {1'b1, 64'h0});
        test_mid_run_start();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
